// File: rtl/des_pkg.sv
// Constant tables and bit-mapping helpers for the DES Feistel f-function.
// DES bit i of an N-bit word lives at vector bit [N-i].
package des_pkg;

    localparam int DES_HALF_W     = 32;
    localparam int DES_KEY_W      = 48;
    localparam int DES_SBOX_IN_W  = 6;
    localparam int DES_SBOX_OUT_W = 4;

    localparam int E_TABLE [DES_KEY_W] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [DES_HALF_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // One 256-bit word per S-box: 64 nibbles, entry 0 in the top nibble, entry = row*16 + col.
    localparam logic [255:0] SBOX_TABLE [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [DES_KEY_W-1:0] des_expand(input logic [DES_HALF_W-1:0] r);
        logic [DES_KEY_W-1:0] e;
        e = '0;
        for (int i = 0; i < DES_KEY_W; i++) begin
            e[6'(DES_KEY_W - 1 - i)] = r[5'(DES_HALF_W - E_TABLE[6'(i)])];
        end
        return e;
    endfunction

    function automatic logic [DES_HALF_W-1:0] des_permute_p(input logic [DES_HALF_W-1:0] s);
        logic [DES_HALF_W-1:0] p;
        p = '0;
        for (int i = 0; i < DES_HALF_W; i++) begin
            p[5'(DES_HALF_W - 1 - i)] = s[5'(DES_HALF_W - P_TABLE[5'(i)])];
        end
        return p;
    endfunction

    // Outer bits (MSB, LSB) select the row, middle four the column.
    function automatic logic [DES_SBOX_OUT_W-1:0] des_sbox(input logic [2:0] box,
                                                           input logic [DES_SBOX_IN_W-1:0] din);
        logic [5:0] idx;
        idx = {din[5], din[0], din[4:1]};
        return SBOX_TABLE[box][(8'd255 - {idx, 2'b00}) -: 4];
    endfunction

endpackage

// File: rtl/des_f_function_pipe_if.sv
// Streaming bus of the f-function pipe: R/subkey in, f(R,K) out.
// Valid/ready: a beat moves on a rising edge where valid & ready; the source holds valid and data stable until then.
interface des_f_function_pipe_if;
    import des_pkg::*;

    logic                  InValid;
    logic                  InReady;
    logic [DES_HALF_W-1:0] RIn;
    logic [DES_KEY_W-1:0]  SubKey;
    logic                  OutValid;
    logic                  OutReady;
    logic [DES_HALF_W-1:0] FOut;

    modport master (
        output InValid, RIn, SubKey, OutReady,
        input  InReady, OutValid, FOut
    );

    modport slave (
        input  InValid, RIn, SubKey, OutReady,
        output InReady, OutValid, FOut
    );

endinterface

// File: rtl/des_sbox_bank.sv
// Combinational S1..S8 substitution followed by the P permutation (48-bit in, 32-bit out).
module des_sbox_bank
    import des_pkg::*;
(
    input  logic [DES_KEY_W-1:0]  data_in,
    output logic [DES_HALF_W-1:0] data_out
);

    logic [DES_HALF_W-1:0] s_out;

    // Chunk 1 (top six bits) feeds S1, whose nibble lands at the top of s_out.
    for (genvar j = 0; j < 8; j++) begin : g_sbox
        assign s_out[DES_HALF_W-1-DES_SBOX_OUT_W*j -: DES_SBOX_OUT_W] =
            des_sbox(3'(j), data_in[DES_KEY_W-1-DES_SBOX_IN_W*j -: DES_SBOX_IN_W]);
    end

    assign data_out = des_permute_p(s_out);

endmodule

// File: rtl/des_f_function_pipe.sv
// Pipelined DES f-function: E-expand, key XOR, S-boxes, P into a registered output.
// Define DES_F_PIPE2_EN to register E^K before the S-boxes (2-cycle latency instead of 1).
module des_f_function_pipe
    import des_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    des_f_function_pipe_if.slave  bus
);

    logic                  in_ready;
    logic                  c_load;
    logic [DES_KEY_W-1:0]  sbox_in;
    logic [DES_HALF_W-1:0] f_value;
    logic                  out_valid;
    logic [DES_HALF_W-1:0] f_out;

    des_sbox_bank u_sbox_bank (
        .data_in  (sbox_in),
        .data_out (f_value)
    );

`ifdef DES_F_PIPE2_EN
    logic                 a_valid;
    logic [DES_KEY_W-1:0] x_reg;
    logic                 a_leaves;

    // Stage A refills in the same cycle its contents move into the output stage.
    assign a_leaves = a_valid & (!out_valid | bus.OutReady);
    assign in_ready = !a_valid | a_leaves;
    assign sbox_in  = x_reg;
    assign c_load   = a_leaves;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_valid <= 1'b0;
            x_reg   <= '0;
        end else if (in_ready) begin
            a_valid <= bus.InValid;
            if (bus.InValid) begin
                x_reg <= des_expand(bus.RIn) ^ bus.SubKey;
            end
        end
    end
`else
    assign in_ready = !out_valid | bus.OutReady;
    assign sbox_in  = des_expand(bus.RIn) ^ bus.SubKey;
    assign c_load   = bus.InValid & in_ready;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            f_out     <= '0;
        end else if (c_load) begin
            out_valid <= 1'b1;
            f_out     <= f_value;
        end else if (bus.OutReady) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.FOut     = f_out;

endmodule

// File: tb/tb_des_f_function_pipe.sv
// Self-checking bench for des_f_function_pipe: DES-bit-level reference model, scoreboard queue,
// directed latency/backpressure/reset cases and randomized valid/ready traffic.
module tb_des_f_function_pipe;

  localparam int RDY_ON   = 0;
  localparam int RDY_OFF  = 1;
  localparam int RDY_RAND = 2;

`ifdef DES_F_PIPE2_EN
  localparam int EXP_LAT = 2;
  localparam int DEPTH   = 2;
`else
  localparam int EXP_LAT = 1;
  localparam int DEPTH   = 1;
`endif

  localparam int E_TAB [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
  };

  localparam int P_TAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };

  localparam int S_TAB [8][4][16] = '{
    '{'{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
      '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
      '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
      '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}},
    '{'{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
      '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
      '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
      '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9}},
    '{'{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1},
      '{13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7},
      '{1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12}},
    '{'{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15},
      '{13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9},
      '{10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4},
      '{3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14}},
    '{'{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
      '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
      '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
      '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3}},
    '{'{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
      '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
      '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
      '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13}},
    '{'{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1},
      '{13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6},
      '{1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2},
      '{6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12}},
    '{'{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7},
      '{1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2},
      '{7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8},
      '{2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}}
  };

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;

  des_f_function_pipe_if bus();

  des_f_function_pipe dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = RDY_ON;
  logic [31:0] exp_q[$];
  logic prev_stall = 1'b0;
  logic [31:0] prev_f = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (DES bit numbering) ----------------
  function automatic logic [47:0] model_x(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    x = '0;
    for (int i = 1; i <= 48; i++) x[48 - i] = r[32 - E_TAB[i - 1]] ^ k[48 - i];
    return x;
  endfunction

  function automatic logic [31:0] model_sbox(input logic [47:0] x);
    logic [31:0] acc;
    bit d[6];
    int row, col;
    acc = '0;
    for (int b = 0; b < 8; b++) begin
      for (int m = 0; m < 6; m++) d[m] = x[47 - 6 * b - m];
      row = 2 * int'(d[0]) + int'(d[5]);
      col = 8 * int'(d[1]) + 4 * int'(d[2]) + 2 * int'(d[3]) + int'(d[4]);
      acc = (acc << 4) | 32'(S_TAB[b][row][col]);
    end
    return acc;
  endfunction

  function automatic logic [31:0] model_p(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int i = 1; i <= 32; i++) p[32 - i] = s[32 - P_TAB[i - 1]];
    return p;
  endfunction

  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
    return model_p(model_sbox(model_x(r, k)));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ready(input int m);
    ready_mode = m;
    if (m == RDY_ON) bus.OutReady = 1'b1;
    else if (m == RDY_OFF) bus.OutReady = 1'b0;
    else bus.OutReady = 1'($urandom_range(1));
  endtask

  // Enter and leave at posedge+1; InValid stays high so back-to-back calls stream without gaps.
  task automatic send(input logic [31:0] r, input logic [47:0] k, output int waited);
    bit acc;
    waited = 0;
    bus.InValid = 1'b1;
    bus.RIn = r;
    bus.SubKey = k;
    do begin
      @(negedge clk);
      acc = bus.InReady;
      waited++;
      @(posedge clk);
      #1;
    end while (!acc && waited < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic stop_in();
    bus.InValid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    set_ready(RDY_ON);
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.OutValid) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rand_key();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // ---------------- OutReady generator ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == RDY_ON) bus.OutReady = 1'b1;
      else if (ready_mode == RDY_OFF) bus.OutReady = 1'b0;
      else bus.OutReady = 1'($urandom_range(1));
    end
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(bus.OutValid), 64'd1);
          check("hold_fout", 64'(bus.FOut), 64'(prev_f));
        end
        if (bus.OutValid && bus.OutReady) begin
          check("out_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) check("fout", 64'(bus.FOut), 64'(exp_q.pop_front()));
        end
        if (bus.InValid && bus.InReady) exp_q.push_back(model_f(bus.RIn, bus.SubKey));
        prev_stall = bus.OutValid && !bus.OutReady;
        prev_f = bus.FOut;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: actual time limit hit, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w, w_total, lat, n;
    logic [31:0] r;
    logic [47:0] k;

    rst = 1'b1;
    bus.InValid = 1'b0;
    bus.RIn = '0;
    bus.SubKey = '0;
    bus.OutReady = 1'b1;

    // Pin the model against the textbook round-1 values.
    check("pin_x", 64'(model_x(32'hF0AAF0AA, 48'h1B02EFFC7072)), 64'h6117BA866527);
    check("pin_sbox", 64'(model_sbox(48'h6117BA866527)), 64'h5C82B597);
    check("pin_p", 64'(model_p(32'h5C82B597)), 64'h234AA9BB);
    check("pin_f", 64'(model_f(32'hF0AAF0AA, 48'h1B02EFFC7072)), 64'h234AA9BB);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.OutValid), 64'd0);
    check("rst_fout", 64'(bus.FOut), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 64'(bus.InReady), 64'd1);
    @(posedge clk);
    #1;

    // Known vector and latency.
    set_ready(RDY_ON);
    send(32'hF0AAF0AA, 48'h1B02EFFC7072, w);
    stop_in();
    lat = 1;
    @(negedge clk);
    while (!bus.OutValid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      @(negedge clk);
    end
    check("t1_latency", 64'(lat), 64'(EXP_LAT));
    check("t1_fout", 64'(bus.FOut), 64'h234AA9BB);
    @(posedge clk);
    #1;
    drain();

    // 64 back-to-back random inputs at full throughput.
    w_total = 0;
    for (int i = 0; i < 64; i++) begin
      send($urandom, rand_key(), w);
      w_total += w;
    end
    stop_in();
    check("t2_accept_cycles", 64'(w_total), 64'd64);
    drain();

    // Single-bit subkey walk.
    for (int b = 0; b < 48; b++) begin
      k = 48'd1 << b;
      send(32'h0, k, w);
    end
    stop_in();
    drain();

    // Backpressure: fill, hold 10 cycles, release.
    set_ready(RDY_OFF);
    for (int i = 0; i < DEPTH; i++) send($urandom, rand_key(), w);
    r = $urandom;
    k = rand_key();
    bus.InValid = 1'b1;
    bus.RIn = r;
    bus.SubKey = k;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_full_in_ready", 64'(bus.InReady), 64'd0);
      check("t3_out_valid", 64'(bus.OutValid), 64'd1);
      @(posedge clk);
      #1;
    end
    set_ready(RDY_ON);
    send(r, k, w);
    stop_in();
    drain();

    // Random traffic: InValid 70%, OutReady 50%.
    set_ready(RDY_RAND);
    n = 0;
    while (n < 1000) begin
      if ($urandom_range(99) < 70) begin
        send($urandom, rand_key(), w);
        n++;
      end else begin
        stop_in();
        @(posedge clk);
        #1;
      end
    end
    stop_in();
    drain();

    // Reset with items in flight.
    set_ready(RDY_OFF);
    for (int i = 0; i < DEPTH; i++) send($urandom, rand_key(), w);
    stop_in();
    rst = 1'b1;
    #1;
    check("t5_out_valid", 64'(bus.OutValid), 64'd0);
    check("t5_fout", 64'(bus.FOut), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_in_ready", 64'(bus.InReady), 64'd1);
    check("t5_no_output", 64'(bus.OutValid), 64'd0);
    @(posedge clk);
    #1;
    set_ready(RDY_ON);
    send(32'h12345678, 48'hA5A5_0F0F_3C3C, w);
    stop_in();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
